// File: rtl/busarb_pkg.sv
// Shared types for the two-master AHB-lite arbiter: master ids, per-master
// transfer state and the address-phase request captured by the hold buffers.
package busarb_pkg;

    localparam int NUM_MASTERS = 2;
    // Width of the stored address; the top-level ADDR_W must not exceed it.
    localparam int REQ_ADDR_W  = 32;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DATA = 2'd2
    } mst_state_e;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0] addr;
        logic                  prot;
        logic [1:0]            size;
        logic                  write;
    } req_t;

endpackage

// File: rtl/busarb_req_buf.sv
// Per-master front end: 1-entry address-phase hold buffer plus the
// IDLE/PEND/DATA state machine that drives this master's hready/hresp.
module busarb_req_buf
    import busarb_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic htrans,
    input  req_t live_req,
    input  logic s_hready,
    input  logic s_hresp,
    input  logic grant,
    output logic hready,
    output logic hresp,
    output logic elig,
    output req_t req
);

    mst_state_e state;
    req_t       hold_req;
    logic       live;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state)
            PEND: hready = 1'b0;
            DATA: begin
                hready = s_hready;
                hresp  = s_hresp;
            end
            default: ;
        endcase
    end

    // A live request is one the master believes accepted: htrans seen with hready high.
    assign live = (state != PEND) && htrans && hready;
    assign elig = (state == PEND) || live;
    assign req  = (state == PEND) ? hold_req : live_req;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else if (grant) begin
            state <= DATA;
        end else if (live) begin
            state <= PEND;
        end else if (state == DATA && s_hready) begin
            state <= IDLE;
        end
    end

    // NOTE: buffer contents need no reset; they are only observed while state is PEND.
    always_ff @(posedge clk) begin
        if (live && !grant) begin
            hold_req <= live_req;
        end
    end

endmodule

// File: rtl/ahb_busarb.sv
// Two-master (m0 data, m1 fetch) to one-slave AHB-lite arbiter. Fixed priority
// m0 > m1 by default; define BUSARB_RR_EN for two-master round-robin.
module ahb_busarb
    import busarb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic              m0_hprot,
    input  logic [1:0]        m0_hsize,
    input  logic              m0_hwrite,
    input  logic [DATA_W-1:0] m0_hwdata,
    input  logic              m0_htrans,
    output logic              m0_hready,
    output logic              m0_hresp,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic              m1_hprot,
    input  logic [1:0]        m1_hsize,
    input  logic              m1_hwrite,
    input  logic [DATA_W-1:0] m1_hwdata,
    input  logic              m1_htrans,
    output logic              m1_hready,
    output logic              m1_hresp,
    output logic [DATA_W-1:0] m_hrdata,
    output logic [ADDR_W-1:0] s_haddr,
    output logic              s_hprot,
    output logic [1:0]        s_hsize,
    output logic              s_hwrite,
    output logic [DATA_W-1:0] s_hwdata,
    output logic              s_htrans,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hresp,
    input  logic              s_hready
);

    logic [NUM_MASTERS-1:0] elig;
    logic [NUM_MASTERS-1:0] grant;
    req_t                   live_req [NUM_MASTERS];
    req_t                   sel_req  [NUM_MASTERS];
    req_t                   win_req;
    master_e                winner;
    logic                   any_elig;
    logic                   owner_valid;
    master_e                owner_id;

    assign live_req[0] = '{addr: REQ_ADDR_W'(m0_haddr), prot: m0_hprot,
                           size: m0_hsize, write: m0_hwrite};
    assign live_req[1] = '{addr: REQ_ADDR_W'(m1_haddr), prot: m1_hprot,
                           size: m1_hsize, write: m1_hwrite};

    busarb_req_buf u_req_buf_m0 (
        .clk      (clk),
        .rstn     (rstn),
        .htrans   (m0_htrans),
        .live_req (live_req[0]),
        .s_hready (s_hready),
        .s_hresp  (s_hresp),
        .grant    (grant[0]),
        .hready   (m0_hready),
        .hresp    (m0_hresp),
        .elig     (elig[0]),
        .req      (sel_req[0])
    );

    busarb_req_buf u_req_buf_m1 (
        .clk      (clk),
        .rstn     (rstn),
        .htrans   (m1_htrans),
        .live_req (live_req[1]),
        .s_hready (s_hready),
        .s_hresp  (s_hresp),
        .grant    (grant[1]),
        .hready   (m1_hready),
        .hresp    (m1_hresp),
        .elig     (elig[1]),
        .req      (sel_req[1])
    );

`ifdef BUSARB_RR_EN
    master_e last_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= M1;
        end else if (s_htrans) begin
            last_grant <= winner;
        end
    end

    // On contention the master granted most recently yields.
    always_comb begin
        if (elig[0] && elig[1]) begin
            winner = (last_grant == M0) ? M1 : M0;
        end else begin
            winner = elig[0] ? M0 : M1;
        end
    end
`else
    assign winner = elig[0] ? M0 : M1;
`endif

    assign any_elig = |elig;
    assign grant[0] = s_hready && any_elig && (winner == M0);
    assign grant[1] = s_hready && any_elig && (winner == M1);

    assign win_req  = (winner == M1) ? sel_req[1] : sel_req[0];
    assign s_htrans = s_hready && any_elig;
    assign s_haddr  = ADDR_W'(win_req.addr);
    assign s_hprot  = win_req.prot;
    assign s_hsize  = win_req.size;
    assign s_hwrite = win_req.write;

    // Data-phase owner follows the address phase by one accepted slave cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_valid <= 1'b0;
            owner_id    <= M0;
        end else if (s_hready) begin
            owner_valid <= s_htrans;
            owner_id    <= winner;
        end
    end

    assign s_hwdata = !owner_valid      ? '0        :
                      (owner_id == M1)  ? m1_hwdata : m0_hwdata;
    assign m_hrdata = s_hrdata;

endmodule
